// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arb instruction/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyDm,
    StResp
  } arb_state_e;

  // Consecutive dm grants tolerated while fetch waits before fetch is forced through.
  localparam int unsigned FAIR_LIMIT = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
module mem_arb_pick (
  input  logic if_req,
  input  logic dm_req,
  input  logic fair_force,
  output logic grant_dm,
  output logic grant_if
);

  // dm has priority unless fairness forces a pending fetch through.
  always_comb begin
    grant_if = if_req & (~dm_req | fair_force);
    grant_dm = dm_req & ~grant_if;
  end

endmodule

// File: rtl/mem_arb.sv
// Arbiter sharing one registered memory port between fetch (if) and data (dm) requesters.
// Optional fairness counter enabled by defining MEM_ARB_FAIR_EN.
module mem_arb
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem
);

  arb_state_e state_q, state_d;
  logic       grant_dm, grant_if, fair_force;
  logic       arb_en, done_if, done_dm;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .fair_force (fair_force),
    .grant_dm   (grant_dm),
    .grant_if   (grant_if)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_dm) begin
          state_d = StBusyDm;
        end else if (grant_if) begin
          state_d = StBusyIf;
        end
      end
      StBusyIf, StBusyDm: begin
        if (mem_ready) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    arb_en    = (state_q == StIdle);
    done_if   = (state_q == StBusyIf) & mem_ready;
    done_dm   = (state_q == StBusyDm) & mem_ready;
    stall_if  = if_req & ~if_ack;
    stall_mem = dm_req & ~dm_ack;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ack <= done_if;
      dm_ack <= done_dm;
      if (done_if) begin
        if_rdata <= mem_rdata;
      end
      // mem_we still holds the captured direction while busy; stores return zero.
      if (done_dm) begin
        dm_rdata <= mem_we ? '0 : mem_rdata;
      end
      if (done_if || done_dm) begin
        mem_req <= 1'b0;
      end else if (arb_en && grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (arb_en && grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end
    end
  end

`ifdef MEM_ARB_FAIR_EN
  logic [1:0] fair_cnt_q;

  // Counts back-to-back dm wins over a waiting fetch; any other outcome restarts the run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fair_cnt_q <= '0;
    end else if (arb_en) begin
      if (grant_if) begin
        fair_cnt_q <= '0;
      end else if (grant_dm) begin
        fair_cnt_q <= if_req ? fair_cnt_q + 2'd1 : 2'd0;
      end
    end
  end

  assign fair_force = (fair_cnt_q == 2'(FAIR_LIMIT));
`else
  assign fair_force = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb with an ack-data scoreboard.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_ack, dm_ack, mem_req, mem_we, stall_if, stall_mem;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];

  mem_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ack must match the next queued expectation for that requester.
  always @(negedge clk) begin
    if (if_ack) begin
      if (exp_if.size() == 0) check("if_ack_unexpected", 32'(if_ack), 32'd0);
      else check("if_rdata_sb", if_rdata, exp_if.pop_front());
    end
    if (dm_ack) begin
      if (exp_dm.size() == 0) check("dm_ack_unexpected", 32'(dm_ack), 32'd0);
      else check("dm_rdata_sb", dm_rdata, exp_dm.pop_front());
    end
  end

  initial begin
    logic [31:0] want[5];
    logic [31:0] got[5];
    logic        prev_req;
    int          grants;

    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

    // Reset state
    tick(); tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_dm_ack", 32'(dm_ack), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    check("idle_ready_ignored", 32'(mem_req), 32'd0);

    // Single fetch, minimum latency
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h2008_0005;
    exp_if.push_back(32'h2008_0005);
    #1 check("fetch_stall_if", 32'(stall_if), 32'd1);
    tick();
    check("fetch_mem_req", 32'(mem_req), 32'd1);
    check("fetch_mem_addr", mem_addr, 32'h40);
    check("fetch_mem_we", 32'(mem_we), 32'd0);
    check("fetch_mem_wdata", mem_wdata, 32'd0);
    check("fetch_no_early_ack", 32'(if_ack), 32'd0);
    tick();
    check("fetch_if_ack", 32'(if_ack), 32'd1);
    check("fetch_if_rdata", if_rdata, 32'h2008_0005);
    check("fetch_req_drop", 32'(mem_req), 32'd0);
    check("fetch_stall_clear", 32'(stall_if), 32'd0);
    if_req = 1'b0; mem_rdata = 32'h1234_5678;
    tick();
    check("fetch_ack_one_cycle", 32'(if_ack), 32'd0);
    check("fetch_rdata_held", if_rdata, 32'h2008_0005);

    // Collision: store wins, fetch served three cycles later
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h1111_2222;
    exp_dm.push_back(32'd0);
    exp_if.push_back(32'h1111_2222);
    tick();
    check("coll_dm_we", 32'(mem_we), 32'd1);
    check("coll_dm_addr", mem_addr, 32'h100);
    check("coll_dm_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("coll_dm_ack", 32'(dm_ack), 32'd1);
    check("coll_store_rdata", dm_rdata, 32'd0);
    check("coll_if_waiting", 32'(stall_if), 32'd1);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    check("coll_resp_no_grant", 32'(mem_req), 32'd0);
    tick();
    check("coll_if_addr", mem_addr, 32'h80);
    check("coll_if_we", 32'(mem_we), 32'd0);
    check("coll_if_wdata", mem_wdata, 32'd0);
    tick();
    check("coll_if_ack_plus3", 32'(if_ack), 32'd1);
    if_req = 1'b0;
    tick();

    // Wait states on a load
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = 32'h55; mem_ready = 1'b0;
    exp_dm.push_back(32'hCAFE_0001);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 32'hBAD0_0000 + 32'(i);
      #1;
      check($sformatf("ws_addr_%0d", i), mem_addr, 32'h200);
      check($sformatf("ws_stall_%0d", i), 32'(stall_mem), 32'd1);
      check($sformatf("ws_no_ack_%0d", i), 32'(dm_ack), 32'd0);
      tick();
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    #1 check("ws_addr_last", mem_addr, 32'h200);
    tick();
    check("ws_dm_ack", 32'(dm_ack), 32'd1);
    check("ws_dm_rdata", dm_rdata, 32'hCAFE_0001);
    dm_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Reset in the middle of a fetch
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    check("rmid_busy", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    check("rmid_mem_req", 32'(mem_req), 32'd0);
    check("rmid_mem_addr", mem_addr, 32'd0);
    check("rmid_if_rdata", if_rdata, 32'd0);
    check("rmid_dm_rdata", dm_rdata, 32'd0);
    tick();
    check("rmid_no_ack", 32'(if_ack), 32'd0);
    check("rmid_idle", 32'(mem_req), 32'd0);
    tick();
    check("rmid_no_ack2", 32'(if_ack), 32'd0);

    // Continuous contention: grant order
`ifdef MEM_ARB_FAIR_EN
    want = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd1};
`else
    want = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
`endif
    for (int i = 0; i < 5; i++) begin
      got[i] = 32'hFFFF_FFFF;
      if (want[i] == 32'd1) exp_dm.push_back(32'h0F0F_0000);
      else exp_if.push_back(32'h0F0F_0000);
    end
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
    if_req = 1'b1; if_addr = 32'h500; mem_rdata = 32'h0F0F_0000;
    grants = 0;
    prev_req = mem_req;
    for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
      tick();
      if (mem_req && !prev_req) begin
        got[grants] = (mem_addr == 32'h400) ? 32'd1 : 32'd0;
        grants++;
      end
      prev_req = mem_req;
    end
    check("fair_grant_count", 32'(grants), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("fair_order_%0d", i), got[i], want[i]);
    tick();
    dm_req = 1'b0; if_req = 1'b0;
    tick(); tick();

    check("sb_if_drained", 32'(exp_if.size()), 32'd0);
    check("sb_dm_drained", 32'(exp_dm.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
